fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V core. Holds the program counter and drives the instruction memory's combinational read port. Captures the returned little-endian word into an IF/ID pipeline register and presents it to decode with a valid/ready handshake. Also handles control-flow redirects from execute, with flush, and an externally requested halt.

## Interface
- `ADDR_WIDTH`, 32: PC and memory address width.
- `DATA_WIDTH`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_addr` out ADDR_WIDTH: byte address to instruction memory; equals the PC register.
- `imem_rdata` in DATA_WIDTH: instruction word at `imem_addr`, valid in the same cycle.
- `redirect_valid` in 1: taken branch/jump from execute; one-cycle pulse.
- `redirect_pc` in ADDR_WIDTH: redirect target.
- `halt_req` in 1: level; while high, no new fetches are issued.
- `id_ready` in 1: decode accepts the IF/ID contents this cycle.
- `id_valid` out 1: IF/ID register holds a live instruction.
- `id_instr` out DATA_WIDTH: fetched instruction.
- `id_pc` out ADDR_WIDTH: address of `id_instr`.
- `id_pc_plus4` out ADDR_WIDTH: `id_pc + 4`, modulo 2^ADDR_WIDTH.
- `misalign_err` out 1: one-cycle pulse, the cycle after a redirect whose target has `[1:0] != 0`.
- `halted` out 1: high in HALT state.

## Operation
- FSM states: BOOT, RUN, HALT. Reset enters BOOT.
- BOOT lasts exactly one cycle, then goes to RUN. No fetch is issued in BOOT.
- RUN goes to HALT when `halt_req`=1 and no fetch load happens that cycle.
- HALT goes back to RUN when `halt_req`=0.
- Load condition: state==RUN, `halt_req`=0, `redirect_valid`=0, and (`id_valid`=0 or `id_ready`=1).
- On load:
  - `id_instr` <= `imem_rdata`; `id_pc` <= PC; `id_pc_plus4` <= PC+4; `id_valid` <= 1.
  - PC <= PC+4, wrapping modulo 2^ADDR_WIDTH.
- If `id_valid`=1, `id_ready`=1 and no load happens: `id_valid` <= 0.
- If `id_valid`=1, `id_ready`=0 and no redirect: all IF/ID fields hold stable and PC holds.
- Redirect has priority over load, halt and stall, and applies in any state except BOOT:
  - PC <= {`redirect_pc`[ADDR_WIDTH-1:2], 2'b00}.
  - `id_valid` <= 0 (flush).
  - `misalign_err` <= (`redirect_pc`[1:0] != 0).
- A redirect during BOOT is ignored.
- A redirect in HALT updates the PC; the state stays HALT.
- `id_instr`, `id_pc` and `id_pc_plus4` are don't-care while `id_valid`=0. They change only on load.
- Reset values: PC=RESET_PC, `id_valid`=0, `id_instr`=0, `id_pc`=0, `id_pc_plus4`=0, `misalign_err`=0, `halted`=0. `imem_addr`=RESET_PC.
- Asserting `rst_n` low mid-operation immediately clears all state to the reset values, including any in-flight IF/ID contents.

## Timing
- Fetch latency: one cycle from PC presented on `imem_addr` to `id_valid`.
- First `id_valid`=1 occurs on the 2nd rising edge after reset release (BOOT, then RUN load), with `id_pc`=RESET_PC.
- Throughput: one instruction per cycle while `id_ready`=1.
- Redirect penalty:
  - Edge N samples `redirect_valid`; the instruction in IF/ID is killed.
  - Edge N+1 loads the target instruction; `id_valid` is 1 after N+1.
- `halt_req` is sampled each edge. The IF/ID entry already held drains normally via `id_ready`.

## Configuration
- Macro `FETCH_PERF_EN`.
- Defined: adds output ports `perf_fetched` (32-bit) and `perf_stalled` (32-bit), both reset to 0.
  - `perf_fetched` increments on every load.
  - `perf_stalled` increments on every RUN cycle with `id_valid`=1 and `id_ready`=0.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset release, RESET_PC=0, `id_ready`=1, memory holds words 0x00500093, 0x00100113 at 0x0 and 0x4 -> `id_valid` rises on the 2nd edge with `id_pc`=0x0 and `id_instr`=0x00500093; the next cycle gives 0x4/0x00100113 and `id_pc_plus4`=0x8.
- Hold `id_ready`=0 for 3 cycles while `id_valid`=1 at `id_pc`=0x8 -> `id_instr`, `id_pc` and `imem_addr`=0xC stay constant; the PC advances to 0x10 only after `id_ready` returns to 1.
- `redirect_valid`=1 with `redirect_pc`=0x100 while `id_pc`=0x10 is pending -> next cycle `id_valid`=0 and `imem_addr`=0x100; the cycle after, `id_pc`=0x100.
- Redirect to 0x203 -> PC=0x200 and `misalign_err` pulses high for exactly one cycle.
- Redirect and `halt_req` asserted in the same cycle; `halt_req` stays high 4 cycles -> PC=target, no loads, `halted`=1; after release, the first load is at the target.
- PC=0xFFFF_FFFC with a load -> next `imem_addr`=0x0, `id_pc_plus4`=0x0. With `FETCH_PERF_EN` defined, `perf_fetched` counts every load across the wrap.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V instruction fetch stage.
// Holds the PC, drives the combinational instruction-memory read port, and
// captures the returned word into an IF/ID register. Decode takes that register
// with a valid/ready handshake.
// A redirect from execute flushes IF/ID and retargets the PC. An external
// halt request stops new fetches.
// Optional feature macro: FETCH_PERF_EN adds the perf_fetched and
// perf_stalled event counters.
module fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt_req,
    input  logic                  id_ready,
    output logic                  id_valid,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [ADDR_WIDTH-1:0] id_pc_plus4,
    output logic                  misalign_err,
    output logic                  halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stalled
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   pc_reg;
    logic                    id_valid_reg;
    logic [DATA_WIDTH-1:0]   id_instr_reg;
    logic [ADDR_WIDTH-1:0]   id_pc_reg;
    logic [ADDR_WIDTH-1:0]   id_pc_plus4_reg;
    logic                    misalign_err_reg;

    logic                    in_boot;
    logic                    in_run;
    logic                    redirect_take;
    logic                    load;
    logic [ADDR_WIDTH-1:0]   pc_plus4;
    logic [ADDR_WIDTH-1:0]   redirect_aligned;

    // Redirects are ignored while booting. Everywhere else they override
    // load, stall and halt.
    assign in_boot          = (state_reg == ST_BOOT);
    assign in_run           = (state_reg == ST_RUN);
    assign redirect_take    = redirect_valid && !in_boot;
    assign load             = in_run && !halt_req && !redirect_valid
                              && (!id_valid_reg || id_ready);
    assign pc_plus4         = pc_reg + PC_STEP;
    assign redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    assign imem_addr    = pc_reg;
    assign id_valid     = id_valid_reg;
    assign id_instr     = id_instr_reg;
    assign id_pc        = id_pc_reg;
    assign id_pc_plus4  = id_pc_plus4_reg;
    assign misalign_err = misalign_err_reg;
    assign halted       = (state_reg == ST_HALT);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. A redirect does not block RUN->HALT, because a
    // redirect cycle never loads.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN:  if (halt_req && !load) state_next = ST_HALT;
            ST_HALT: if (!halt_req) state_next = ST_RUN;
            default: state_next = ST_BOOT;
        endcase
    end

    // PC and IF/ID register: redirect flushes, load captures, and an accepted
    // entry with no replacement drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg           <= RESET_PC;
            id_valid_reg     <= 1'b0;
            id_instr_reg     <= '0;
            id_pc_reg        <= '0;
            id_pc_plus4_reg  <= '0;
            misalign_err_reg <= 1'b0;
        end else begin
            misalign_err_reg <= 1'b0;
            if (redirect_take) begin
                pc_reg           <= redirect_aligned;
                id_valid_reg     <= 1'b0;
                misalign_err_reg <= (redirect_pc[1:0] != 2'b00);
            end else if (load) begin
                id_instr_reg    <= imem_rdata;
                id_pc_reg       <= pc_reg;
                id_pc_plus4_reg <= pc_plus4;
                id_valid_reg    <= 1'b1;
                pc_reg          <= pc_plus4;
            end else if (id_valid_reg && id_ready) begin
                id_valid_reg <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_stalled_reg;

    assign perf_fetched = perf_fetched_reg;
    assign perf_stalled = perf_stalled_reg;

    // Event counters: one count per load, and one per RUN cycle in which decode
    // back-pressures a live entry. Both wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_reg <= '0;
            perf_stalled_reg <= '0;
        end else begin
            if (load) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if (in_run && id_valid_reg && !id_ready) begin
                perf_stalled_reg <= perf_stalled_reg + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table plus randomized checking of fetch_unit
// against a behavioural model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        misalign_err;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalled;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: two fixed words, then a hash of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4),
        .misalign_err  (misalign_err),
        .halted        (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stalled  (perf_stalled)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_instr, m_idpc;
    logic        m_valid, m_booting, m_halted, m_mis;
    logic [31:0] m_fetched, m_stalled;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_idpc = 32'h0;
        m_valid = 1'b0; m_booting = 1'b1; m_halted = 1'b0; m_mis = 1'b0;
        m_fetched = 32'h0; m_stalled = 32'h0;
    endtask

    // One rising edge of the fetch stage, stated as rules on the inputs.
    task automatic model_edge();
        logic fetch, was_boot;
        was_boot = m_booting;
        fetch = !m_booting && !m_halted && !halt_req && !redirect_valid
                && (!m_valid || id_ready);
        if (!m_booting && !m_halted && m_valid && !id_ready) m_stalled++;
        if (fetch) m_fetched++;
        m_mis = 1'b0;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (redirect_valid) begin
            m_pc    = redirect_pc & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            m_mis   = (redirect_pc % 4) != 0;
        end else if (fetch) begin
            m_instr = mem_word(m_pc);
            m_idpc  = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end else if (m_valid && id_ready) begin
            m_valid = 1'b0;
        end
        if (!was_boot) begin
            if (!m_halted && halt_req && !fetch) m_halted = 1'b1;
            else if (m_halted && !halt_req)      m_halted = 1'b0;
        end
    endtask

    task automatic check_model();
        chk("model_imem_addr", imem_addr, m_pc);
        chk("model_id_valid", {31'b0, id_valid}, {31'b0, m_valid});
        chk("model_misalign", {31'b0, misalign_err}, {31'b0, m_mis});
        chk("model_halted", {31'b0, halted}, {31'b0, m_halted});
        if (m_valid) begin
            chk("model_id_instr", id_instr, m_instr);
            chk("model_id_pc", id_pc, m_idpc);
            chk("model_id_pc_plus4", id_pc_plus4, m_idpc + 32'd4);
        end
`ifdef FETCH_PERF_EN
        chk("model_perf_fetched", perf_fetched, m_fetched);
        chk("model_perf_stalled", perf_stalled, m_stalled);
`endif
    endtask

    // Apply the inputs already driven across one edge; compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic r, input logic [31:0] rpc, input logic h, input logic rdy);
        redirect_valid = r; redirect_pc = rpc; halt_req = h; id_ready = rdy;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_imem_addr"}, imem_addr, 32'h0);
        chk({tag, "_id_valid"}, {31'b0, id_valid}, 32'h0);
        chk({tag, "_id_instr"}, id_instr, 32'h0);
        chk({tag, "_id_pc"}, id_pc, 32'h0);
        chk({tag, "_id_pc_plus4"}, id_pc_plus4, 32'h0);
        chk({tag, "_misalign"}, {31'b0, misalign_err}, 32'h0);
        chk({tag, "_halted"}, {31'b0, halted}, 32'h0);
`ifdef FETCH_PERF_EN
        chk({tag, "_perf_fetched"}, perf_fetched, 32'h0);
        chk({tag, "_perf_stalled"}, perf_stalled, 32'h0);
`endif
    endtask

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        halt;
        logic        ready;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] e_idpc;
        logic        e_mis;
        logic        e_halted;
    } vec_t;

    vec_t tbl[19];

    initial begin
        // Directed sequence starting at reset release; one row per edge.
        tbl[0]  = '{1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 32'h000, 32'h000, 1'b0, 1'b0}; // BOOT: redirect ignored
        tbl[1]  = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h004, 32'h000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h008, 32'h004, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h00C, 32'h008, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h00C, 32'h008, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h00C, 32'h008, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h00C, 32'h008, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h010, 32'h00C, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h014, 32'h010, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h100, 32'h000, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h104, 32'h100, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 32'h203, 1'b0, 1'b1, 1'b0, 32'h200, 32'h000, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h204, 32'h200, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 32'h300, 32'h000, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h300, 32'h000, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h300, 32'h000, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h300, 32'h000, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h300, 32'h000, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h304, 32'h300, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].redir, tbl[i].rpc, tbl[i].halt, tbl[i].ready);
            step();
            chk($sformatf("tbl%0d_imem_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_id_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_misalign", i), {31'b0, misalign_err}, {31'b0, tbl[i].e_mis});
            chk($sformatf("tbl%0d_halted", i), {31'b0, halted}, {31'b0, tbl[i].e_halted});
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_id_pc", i), id_pc, tbl[i].e_idpc);
                chk($sformatf("tbl%0d_id_instr", i), id_instr, mem_word(tbl[i].e_idpc));
                chk($sformatf("tbl%0d_id_pc_plus4", i), id_pc_plus4, tbl[i].e_idpc + 32'd4);
            end
        end

        // PC wrap at the top of the address space.
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        step();
        chk("wrap_redirect_addr", imem_addr, 32'hFFFF_FFFC);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_id_pc_plus4", id_pc_plus4, 32'h0);
        chk("wrap_imem_addr", imem_addr, 32'h0);
        step();
        chk("wrap_next_id_pc", id_pc, 32'h0);
        chk("wrap_next_instr", id_instr, 32'h0050_0093);
        $display("directed phase done: %0d checks, %0d failures", checks, fails);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rpc;
            logic        h;
            h = halt_req;
            if ($urandom_range(0, 11) == 0) h = !h;
            case ($urandom_range(0, 3))
                0:       rpc = $urandom_range(0, 255) * 4;
                1:       rpc = $urandom;
                2:       rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: rpc = 32'h1000 + $urandom_range(0, 63);
            endcase
            drive($urandom_range(0, 99) < 8, rpc, h, $urandom_range(0, 99) < 75);
            step();
        end
        $display("random phase done: %0d checks, %0d failures", checks, fails);

        // Asynchronous reset mid-operation: put a live entry in IF/ID first.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset_async");
        @(posedge clk);
        #1;
        check_reset_values("midreset_held");
        model_reset();
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        chk("midreset_boot_valid", {31'b0, id_valid}, 32'h0);
        step();
        chk("midreset_first_pc", id_pc, 32'h0);
        chk("midreset_first_instr", id_instr, 32'h0050_0093);
        step();
        chk("midreset_second_instr", id_instr, 32'h0010_0113);
        chk("midreset_second_pc4", id_pc_plus4, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
